// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver: steers the 4-state protocol FSM to a requested state with the shortest inA/inB pulse sequence.
// Define FSM_SEQ_DRIVER_CHECK_EN to compare OutA/OutB against the model and resync on mismatch.
module fsm_seq_driver #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_state,
    output logic       req_ready,
    output logic       inA,
    output logic       inB,
    input  logic       OutA,
    input  logic       OutB,
    output logic       done,
    output logic       busy,
    output logic [1:0] model_state,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, STEP, GAP} state_t;
    state_t     state_q, state_d;
    logic [1:0] model_q, model_d, target_q, target_d;
    logic [4:0] cnt_q, cnt_d;
    logic       fwd_q, fwd_d, ina_q, ina_d, inb_q, inb_d, done_q, done_d, err_q, err_d;
    logic [1:0] cur, tgt, diff;
    logic       mis, fwd, pat_a;
`ifdef FSM_SEQ_DRIVER_CHECK_EN
    assign mis = (state_q == GAP) && (cnt_q == 5'd0) && ({OutA, OutB} != model_q);
    assign cur = mis ? {OutA, OutB} : model_q;
`else
    logic unused_out;
    assign unused_out = OutA ^ OutB;
    assign mis = 1'b0;
    assign cur = model_q;
`endif
    // Path is recomputed from the (possibly resynced) state before every step.
    assign tgt   = (state_q == IDLE) ? req_state : target_q;
    assign diff  = tgt - cur;
    assign fwd   = diff != 2'd3;
    assign pat_a = fwd ^ cur[0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            model_q  <= 2'd0;
            target_q <= 2'd0;
            cnt_q    <= 5'd0;
            fwd_q    <= 1'b0;
            ina_q    <= 1'b0;
            inb_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            model_q  <= model_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            fwd_q    <= fwd_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        model_d  = mis ? cur : model_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        fwd_d    = fwd_q;
        ina_d    = 1'b0;
        inb_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q | mis;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_state;
                    if (diff == 2'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = STEP;
                        fwd_d   = fwd;
                        ina_d   = pat_a;
                        inb_d   = ~pat_a;
                    end
                end
            end
            STEP: begin
                model_d = fwd_q ? model_q + 2'd1 : model_q - 2'd1;
                cnt_d   = 5'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else if (diff == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = STEP;
                    fwd_d   = fwd;
                    ina_d   = pat_a;
                    inb_d   = ~pat_a;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign req_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign inA         = ina_q;
    assign inB         = inb_q;
    assign done        = done_q;
    assign model_state = model_q;
`ifdef FSM_SEQ_DRIVER_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
